sata_link_tx_crc_appender: RTL and testbench

- Sits directly downstream of the TX link FIFO. Drains FIFO words through the FIFO's showahead read interface.
- Computes the SerialATA frame CRC over all data dwords of each frame and appends it as the final dword.
- Presents the result on a valid/ready stream to the link TX framer/scrambler stage.
- The framer turns output bubbles into HOLD primitives; this block only guarantees word order, framing flags and CRC.

---
 rtl/sata_link_tx_crc_appender.sv | 115 +++++++++++
 tb/tb_sata_link_tx_crc_appender.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sata_link_tx_crc_appender.sv
// Purpose: drains the showahead TX link FIFO, computes the SATA frame CRC over each
//   frame's data dwords and appends the CRC as the frame's final dword.
// Latency: one cycle from FIFO head to tx_*; the CRC dword takes the next free slot after eop.
// Backpressure: the output register holds while tx_valid & ~tx_ready; no FIFO pop then.
// Ports:
//   clk, reset (async, active-low)
//   fifo_data/fifo_eop/fifo_err/fifo_empty in, fifo_rdreq out: showahead FIFO read side
//   tx_data/tx_sop/tx_eop/tx_err/tx_valid out, tx_ready in: valid/ready stream to the framer
module sata_link_tx_crc_appender #(
  parameter logic [31:0] CRC_INIT = 32'h52325032,
  parameter logic [31:0] CRC_POLY = 32'h04C11DB7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fifo_data,
  input  logic        fifo_eop,
  input  logic        fifo_err,
  output logic        fifo_rdreq,
  input  logic        fifo_empty,
  output logic [31:0] tx_data,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic        tx_err,
  output logic        tx_valid,
  input  logic        tx_ready
);

  typedef enum logic {ST_DATA, ST_CRC} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] crc;
  logic        first;
  logic        err_acc;
  logic        slot_free;
  logic        pop;
  logic        crc_load;

  // 32 bit-serial CRC steps, MSB of the data word first, unrolled into one cycle.
  function automatic logic [31:0] crc_next(input logic [31:0] c_in, input logic [31:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_DATA;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_DATA: if (pop && fifo_eop) state_nxt = ST_CRC;
      ST_CRC:  if (slot_free)       state_nxt = ST_DATA;
      default: state_nxt = ST_DATA;
    endcase
  end

  // Output / control logic. The pop is gated by reset so the FIFO is never
  // drained while the block is held in reset.
  always_comb begin
    slot_free  = ~tx_valid | tx_ready;
    pop        = reset & (state == ST_DATA) & ~fifo_empty & slot_free;
    crc_load   = (state == ST_CRC) & slot_free;
    fifo_rdreq = pop;
  end

  // Output register and per-frame CRC / error accumulation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data  <= 32'h0;
      tx_sop   <= 1'b0;
      tx_eop   <= 1'b0;
      tx_err   <= 1'b0;
      tx_valid <= 1'b0;
      crc      <= CRC_INIT;
      first    <= 1'b1;
      err_acc  <= 1'b0;
    end else if (pop) begin
      tx_data  <= fifo_data;
      tx_sop   <= first;
      tx_eop   <= 1'b0;
      tx_err   <= 1'b0;
      tx_valid <= 1'b1;
      crc      <= crc_next(crc, fifo_data);
      err_acc  <= err_acc | fifo_err;
      first    <= 1'b0;
    end else if (crc_load) begin
      // crc already includes the eop dword; restart accumulation for the next frame.
      tx_data  <= crc;
      tx_sop   <= 1'b0;
      tx_eop   <= 1'b1;
      tx_err   <= err_acc;
      tx_valid <= 1'b1;
      crc      <= CRC_INIT;
      err_acc  <= 1'b0;
      first    <= 1'b1;
    end else if (slot_free) begin
      // Nothing to send: bubble. crc/first/err_acc are kept across FIFO underruns.
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sata_link_tx_crc_appender.sv
// Purpose: self-checking bench for sata_link_tx_crc_appender with a queue-based FIFO model
//   and an independent CRC model (polynomial long division of (crc ^ dword) * x^32).
// Ports: none (top-level bench).
module tb_sata_link_tx_crc_appender;

  localparam logic [31:0] CRC_INIT = 32'h52325032;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fifo_data;
  logic        fifo_eop;
  logic        fifo_err;
  logic        fifo_rdreq;
  logic        fifo_empty;
  logic [31:0] tx_data;
  logic        tx_sop;
  logic        tx_eop;
  logic        tx_err;
  logic        tx_valid;
  logic        tx_ready;

  sata_link_tx_crc_appender #(.CRC_INIT(CRC_INIT), .CRC_POLY(CRC_POLY)) dut (
    .clk(clk), .reset(reset),
    .fifo_data(fifo_data), .fifo_eop(fifo_eop), .fifo_err(fifo_err),
    .fifo_rdreq(fifo_rdreq), .fifo_empty(fifo_empty),
    .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_err(tx_err),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] data; logic eop; logic err; } fent_t;
  typedef struct packed { logic [31:0] data; logic sop; logic eop; logic err; } word_t;

  fent_t fq[$];
  word_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_crc   = CRC_INIT;
  logic        m_first = 1'b1;
  logic        m_err   = 1'b0;
  int          n_data  = 0;

  int          cyc, pops, bubbles, first_acc, last_acc;
  int          ready_mode = 0;
  int          gap_after = 0, gap_len = 0, gap_cnt = 0;
  logic        pending_pop = 1'b0;
  logic        prev_stall  = 1'b0;
  logic [35:0] prev_out    = '0;
  logic        in_frame    = 1'b0;
  logic [31:0] last_crc    = '0;
  logic [31:0] crc_ref;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // CRC of one dword as remainder of ((c ^ d) * x^32) mod P.
  function automatic logic [31:0] mdl_crc(input logic [31:0] c, input logic [31:0] d);
    logic [63:0] r;
    r = {c ^ d, 32'h0};
    for (int i = 63; i >= 32; i--)
      if (r[i]) r[i -: 33] = r[i -: 33] ^ {1'b1, CRC_POLY};
    return r[31:0];
  endfunction

  task automatic add_word(input logic [31:0] d, input logic eop, input logic err);
    fq.push_back('{data: d, eop: eop, err: err});
    exp_q.push_back('{data: d, sop: m_first, eop: 1'b0, err: 1'b0});
    m_first = 1'b0;
    m_crc   = mdl_crc(m_crc, d);
    m_err   = m_err | err;
    n_data++;
    if (eop) begin
      exp_q.push_back('{data: m_crc, sop: 1'b0, eop: 1'b1, err: m_err});
      m_crc = CRC_INIT; m_err = 1'b0; m_first = 1'b1;
    end
  endtask

  task automatic step();
    word_t e;
    logic  gap_active;
    @(negedge clk);
    if (pending_pop) void'(fq.pop_front());
    cyc++;
    case (ready_mode)
      1:       tx_ready = (cyc % 2) == 1;
      2:       tx_ready = !(cyc >= 4 && cyc < 9);
      default: tx_ready = 1'b1;
    endcase
    gap_active = (gap_len > 0) && (pops == gap_after) && (gap_cnt < gap_len);
    if (gap_active) gap_cnt++;
    if (fq.size() == 0 || gap_active) begin
      fifo_empty = 1'b1; fifo_data = 32'hDEAD_BEEF; fifo_eop = 1'b0; fifo_err = 1'b0;
    end else begin
      fifo_empty = 1'b0; fifo_data = fq[0].data; fifo_eop = fq[0].eop; fifo_err = fq[0].err;
    end
    #1;
    if (prev_stall) check_eq("hold_stable", {tx_valid, tx_sop, tx_eop, tx_err, tx_data}, prev_out);
    if (tx_valid && !tx_ready) check_eq("rdreq_stall", fifo_rdreq, 0);
    if (fifo_empty) check_eq("rdreq_empty", fifo_rdreq, 0);
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_word", {tx_data, tx_sop, tx_eop, tx_err}, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("word", {tx_data, tx_sop, tx_eop, tx_err}, {e.data, e.sop, e.eop, e.err});
      end
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      if (tx_sop) in_frame = 1'b1;
      if (tx_eop) begin in_frame = 1'b0; last_crc = tx_data; end
    end else if (in_frame && !tx_valid) begin
      bubbles++;
    end
    pending_pop = fifo_rdreq;
    if (fifo_rdreq) pops++;
    prev_stall = tx_valid & ~tx_ready;
    prev_out   = {tx_valid, tx_sop, tx_eop, tx_err, tx_data};
  endtask

  // Runs until every queued word has been observed (bounded), then checks
  // pop count, output span (if exp_span >= 0) and bubble count.
  task automatic run(input int exp_span, input int exp_bubbles);
    int n;
    cyc = 0; pops = 0; bubbles = 0; first_acc = -1; last_acc = -1; gap_cnt = 0;
    n = 0;
    while ((exp_q.size() != 0 || fq.size() != 0) && n < 300) begin
      step(); n++;
    end
    step(); step();
    check_eq("leftover_words", exp_q.size(), 0);
    check_eq("fifo_pops", pops, n_data);
    if (exp_span >= 0) check_eq("span", last_acc - first_acc + 1, exp_span);
    check_eq("bubbles", bubbles, exp_bubbles);
    n_data = 0; gap_len = 0; ready_mode = 0;
  endtask

  initial begin
    reset = 1'b0; tx_ready = 1'b1;
    fifo_empty = 1'b0; fifo_data = 32'h1234_5678; fifo_eop = 1'b0; fifo_err = 1'b1;
    // Reset with a non-empty FIFO head
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_outputs", {tx_valid, tx_sop, tx_eop, tx_err, tx_data}, 0);
    check_eq("rst_rdreq", fifo_rdreq, 0);
    fifo_empty = 1'b1; fifo_err = 1'b0;
    @(negedge clk); reset = 1'b1;

    // Single-dword frame of zero
    add_word(32'h0000_0000, 1'b1, 1'b0);
    run(2, 0);

    // Back-to-back 3- and 2-dword frames, contiguous output
    add_word(32'h1111_1111, 1'b0, 1'b0);
    add_word(32'h2222_2222, 1'b0, 1'b0);
    add_word(32'h3333_3333, 1'b1, 1'b0);
    add_word(32'hAAAA_AAAA, 1'b0, 1'b0);
    add_word(32'hBBBB_BBBB, 1'b1, 1'b0);
    run(7, 0);

    // Backpressure: tx_ready toggling every cycle
    ready_mode = 1;
    add_word(32'hCAFE_0001, 1'b0, 1'b0);
    add_word(32'hCAFE_0002, 1'b0, 1'b0);
    add_word(32'hCAFE_0003, 1'b0, 1'b0);
    add_word(32'hCAFE_0004, 1'b1, 1'b0);
    add_word(32'h0BAD_F00D, 1'b1, 1'b0);
    run(-1, 0);

    // Backpressure: tx_ready held low 5 cycles mid-frame
    ready_mode = 2;
    add_word(32'h0102_0304, 1'b0, 1'b0);
    add_word(32'h0506_0708, 1'b0, 1'b0);
    add_word(32'h090A_0B0C, 1'b0, 1'b0);
    add_word(32'h0D0E_0F10, 1'b1, 1'b0);
    run(-1, 0);

    // 4-dword frame without and with a 4-cycle FIFO underrun after dword 2
    add_word(32'hDEAD_0001, 1'b0, 1'b0);
    add_word(32'hDEAD_0002, 1'b0, 1'b0);
    add_word(32'hDEAD_0003, 1'b0, 1'b0);
    add_word(32'hDEAD_0004, 1'b1, 1'b0);
    run(5, 0);
    crc_ref = last_crc;
    gap_after = 2; gap_len = 4;
    add_word(32'hDEAD_0001, 1'b0, 1'b0);
    add_word(32'hDEAD_0002, 1'b0, 1'b0);
    add_word(32'hDEAD_0003, 1'b0, 1'b0);
    add_word(32'hDEAD_0004, 1'b1, 1'b0);
    run(9, 4);
    check_eq("crc_gap_vs_nogap", last_crc, crc_ref);

    // Error on dword 2 of a 3-dword frame, then a clean frame
    add_word(32'h5555_0001, 1'b0, 1'b0);
    add_word(32'h5555_0002, 1'b0, 1'b1);
    add_word(32'h5555_0003, 1'b1, 1'b0);
    add_word(32'h6666_0001, 1'b0, 1'b0);
    add_word(32'h6666_0002, 1'b1, 1'b0);
    run(7, 0);

    // Reset in the middle of a frame: partial frame and CRC are discarded
    add_word(32'h7777_0001, 1'b0, 1'b0);
    add_word(32'h7777_0002, 1'b0, 1'b0);
    add_word(32'h7777_0003, 1'b1, 1'b0);
    cyc = 0; pops = 0;
    step(); step();
    @(negedge clk);
    reset = 1'b0;
    if (pending_pop) void'(fq.pop_front());
    fifo_empty = 1'b0; fifo_data = fq[0].data; fifo_eop = fq[0].eop; fifo_err = fq[0].err;
    #1;
    check_eq("midrst_outputs", {tx_valid, tx_sop, tx_eop, tx_err, tx_data}, 0);
    check_eq("midrst_rdreq", fifo_rdreq, 0);
    fq.delete(); exp_q.delete();
    m_crc = CRC_INIT; m_first = 1'b1; m_err = 1'b0; n_data = 0;
    pending_pop = 1'b0; prev_stall = 1'b0; in_frame = 1'b0;
    fifo_empty = 1'b1;
    @(negedge clk); reset = 1'b1;
    add_word(32'h8888_0001, 1'b0, 1'b0);
    add_word(32'h8888_0002, 1'b1, 1'b0);
    run(3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
